xc_uart_rx: RTL
===============

# xc_uart_rx

Host-command receive path of the XC correlator: deserialises 8N1 UART frames arriving on the board RX pin and hands bytes to the command decoder in `main` through a valid/ready handshake. It is the receiving counterpart of the existing correlation-data transmitter on TX and shares its `CLK_FREQUENCY`/`BAUD_RATE` parameters. It provides start-bit glitch rejection, framing-error and overrun reporting, and a small elastic buffer.

## Interface
Parameters:
- `CLK_FREQUENCY`, 10000000: frequency of `clk` in Hz.
- `BAUD_RATE`, 57600: line rate in bit/s.
- `FIFO_DEPTH`, 4: byte buffer entries; must be a power of two, minimum 2.

Ports:
- `clk` input 1: the only clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-high.
- `rx` input 1: raw UART line, asynchronous to `clk`, idle high.
- `out_data` output 8: byte at the FIFO head.
- `out_valid` output 1: FIFO not empty.
- `out_ready` input 1: consumer accepts `out_data` when `out_valid && out_ready`.
- `framing_error` output 1: one-cycle pulse when a stop bit is sampled low.
- `overrun` output 1: one-cycle pulse when a complete byte is dropped because the FIFO is full.
- `busy` output 1: high while a frame is being received (any state other than IDLE).

## Operation
- Derived constants: `BIT_TICKS = (CLK_FREQUENCY + BAUD_RATE/2) / BAUD_RATE` (174 at the default parameters); `HALF_TICKS = BIT_TICKS/2` (87). The tick counter is `$clog2(BIT_TICKS)` bits wide and counts down to zero.
- `rx` passes through a 2-flop synchroniser. Both flops reset to 1. All decisions use the synchronised value `rx_s`.
- FSM states:
  - IDLE: when `rx_s` is 0, load `HALF_TICKS` and go to START.
  - START: when the counter reaches 0, sample `rx_s`. If it is 1 (glitch), return to IDLE with no output. If it is 0, load `BIT_TICKS`, clear the bit index, and go to DATA.
  - DATA: each time the counter reaches 0, shift `rx_s` into the shift register LSB-first and reload `BIT_TICKS`. After bit index 7, go to STOP.
  - STOP: when the counter reaches 0, sample `rx_s`. If it is 1, push the byte and go to IDLE. If it is 0, pulse `framing_error`, discard the byte, and go to BREAK.
  - BREAK: wait for `rx_s` to be 1, then go to IDLE. This prevents a held-low line from being read as a stream of 0x00 frames.
- FIFO behaviour:
  - A push while full drops the incoming byte, pulses `overrun`, and leaves the stored contents unchanged.
  - If a pop and a push happen in the same cycle while full, the pop frees the slot and the push is accepted, with no overrun.
  - Bytes are delivered in arrival order.
- `out_data` is registered from the head entry and holds its value while `out_valid && !out_ready`.
- Reset mid-frame abandons the frame, empties the FIFO, and returns to IDLE. A partially received frame that is still on the line after reset is resynchronised at the next falling edge seen in IDLE.

## Timing
- Reset values: `out_data`=0x00, `out_valid`=0, `framing_error`=0, `overrun`=0, `busy`=0. FSM state is IDLE and FIFO pointers are 0.
- Latency: from an `rx` falling edge to `out_valid` rising is `3 + HALF_TICKS + 9*BIT_TICKS + 1` cycles (1657 at the defaults). The bench accepts ±2 cycles.
- Sampling points land at mid-bit to within 3 cycles, which gives a baud-mismatch tolerance of at least ±3% at the defaults.
- Back-to-back frames: IDLE is re-entered half a bit before the stop bit ends, so a start edge immediately after the stop bit is captured.
- `framing_error` and `overrun` are asserted in the cycle after the STOP sample.
- `out_valid` falls in the cycle after the pop of the last entry.

## Structure
- Package `xc_uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, STOP, BREAK);
  - a function `bit_ticks(clk_hz, baud)` returning the rounded quotient;
  - the constant `UART_DATA_BITS = 8`, shared with the transmitter.
- Sub-module `xc_byte_fifo` provides a synchronous FIFO with parameters `WIDTH` and `DEPTH` and ports `push`, `din`, `pop`, `dout`, `empty`, `full`. It uses one extra pointer bit to distinguish full from empty, and is reusable by the TX path.

## Test plan
- Send 0xA5 at exactly 57600 baud with `out_ready`=1. Expect `out_data`=0xA5 with `out_valid` high for 1 cycle, about 1657 cycles after the start edge, and no error pulses.
- Drive an `rx` low glitch of 40 cycles, then hold the line idle. Expect START to abort, `out_valid` to stay 0, and `busy` to fall back to 0 within 90 cycles.
- Send a 0x00 frame with the stop bit low, hold `rx` low for 3000 cycles, then send 0x3C. Expect exactly one `framing_error` pulse, no push during the break, and then 0x3C delivered.
- Send 0x01..0x05 back-to-back with `out_ready`=0. Expect `overrun` to pulse once, on byte 0x05. Then raise `out_ready`; expect reads of 0x01, 0x02, 0x03, 0x04, followed by `out_valid`=0.
- Assert `reset` for 1 cycle during DATA bit 4 of a frame that follows a stored byte. Expect all outputs to hold their reset values, the FIFO to be empty, and the next clean frame 0x5A to be received correctly.
- Send 0x55 and 0xAA at a +3% baud error, then at a −3% error. Expect both bytes to be received correctly at each rate.

Source files
------------

// File: rtl/xc_uart_pkg.sv
// Shared UART definitions for the XC correlator host link: receiver FSM
// states, the bit-period helper and the frame data width.
package xc_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_e;

    // Clock cycles per UART bit, rounded to the nearest integer.
    function automatic int bit_ticks(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/xc_byte_fifo.sv
// Small synchronous FIFO with a registered head output. One extra pointer
// bit tells full from empty. A push while full is only accepted when a pop
// frees a slot in the same cycle.
module xc_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_next_s;
    logic [PTR_W-1:0] rd_next_s;
    logic             empty_r;
    logic             full_r;
    logic [WIDTH-1:0] dout_r;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             empty_next_s;
    logic             full_next_s;
    logic             bypass_s;
    logic [WIDTH-1:0] head_next_s;

    // Next pointers, flags and the value that will sit at the head after this cycle.
    always_comb begin
        pop_ok_s     = pop & ~empty_r;
        push_ok_s    = push & (~full_r | pop_ok_s);
        wr_next_s    = wr_ptr_r + {{ADDR_W{1'b0}}, push_ok_s};
        rd_next_s    = rd_ptr_r + {{ADDR_W{1'b0}}, pop_ok_s};
        empty_next_s = (wr_next_s == rd_next_s);
        full_next_s  = (wr_next_s[ADDR_W] != rd_next_s[ADDR_W]) &&
                       (wr_next_s[ADDR_W-1:0] == rd_next_s[ADDR_W-1:0]);
        // The incoming byte becomes the head when it lands in the slot the
        // read pointer is about to point at (FIFO empty after any pop).
        bypass_s     = push_ok_s && (wr_ptr_r == rd_next_s);
        head_next_s  = bypass_s ? din : mem_r[rd_next_s[ADDR_W-1:0]];
    end

    // Storage array write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r[ADDR_W-1:0]] <= din;
        end
    end

    // Pointers, status flags and the registered head byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            dout_r   <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_r <= wr_next_s;
            rd_ptr_r <= rd_next_s;
            empty_r  <= empty_next_s;
            full_r   <= full_next_s;
            if (!empty_next_s) begin
                dout_r <= head_next_s;
            end else begin
                dout_r <= dout_r;
            end
        end
    end

    assign dout  = dout_r;
    assign empty = empty_r;
    assign full  = full_r;

endmodule

// File: rtl/xc_uart_rx.sv
// 8N1 UART receiver for host commands. Synchronises the RX pin, rejects
// short start-bit glitches, samples each bit near its middle, reports
// framing errors and overruns, and buffers bytes in a small FIFO that
// feeds a valid/ready consumer.
module xc_uart_rx
    import xc_uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 10000000,
    parameter int BAUD_RATE     = 57600,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
);

    localparam int BIT_TICKS  = bit_ticks(CLK_FREQUENCY, BAUD_RATE);
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int CNT_W      = $clog2(BIT_TICKS);
    localparam int IDX_W      = $clog2(UART_DATA_BITS);

    // The zero tick itself is the last cycle of a period, so a full bit
    // reloads one less than BIT_TICKS to keep the sample spacing exact.
    localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(HALF_TICKS);
    localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(UART_DATA_BITS - 1);

    logic                      rx_meta_r;
    logic                      rx_sync_r;
    logic                      rx_s;
    uart_rx_state_e            state_r;
    uart_rx_state_e            state_next_s;
    logic [CNT_W-1:0]          cnt_r;
    logic [CNT_W-1:0]          cnt_next_s;
    logic [IDX_W-1:0]          bit_idx_r;
    logic [IDX_W-1:0]          bit_idx_next_s;
    logic [UART_DATA_BITS-1:0] shift_r;
    logic [UART_DATA_BITS-1:0] shift_next_s;
    logic                      tick_s;
    logic                      push_s;
    logic                      fe_set_s;
    logic                      ov_set_s;
    logic                      fe_r;
    logic                      ov_r;
    logic                      busy_r;
    logic [UART_DATA_BITS-1:0] fifo_dout_s;
    logic                      fifo_empty_s;
    logic                      fifo_full_s;

    // Two-flop synchroniser for the asynchronous RX pin; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    assign rx_s = rx_sync_r;

    // Frame FSM: next state, bit timer, bit index, shift register and push.
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        bit_idx_next_s = bit_idx_r;
        shift_next_s   = shift_r;
        push_s         = 1'b0;
        fe_set_s       = 1'b0;
        tick_s         = (cnt_r == CNT_ZERO);
        case (state_r)
            IDLE: begin
                if (!rx_s) begin
                    state_next_s = START;
                    cnt_next_s   = HALF_LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    if (rx_s) begin
                        // Line went back high before mid start bit: glitch.
                        state_next_s = IDLE;
                    end else begin
                        state_next_s   = DATA;
                        cnt_next_s     = BIT_RELOAD;
                        bit_idx_next_s = IDX_ZERO;
                    end
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            DATA: begin
                if (tick_s) begin
                    shift_next_s = {rx_s, shift_r[UART_DATA_BITS-1:1]};
                    cnt_next_s   = BIT_RELOAD;
                    if (bit_idx_r == IDX_LAST) begin
                        state_next_s = STOP;
                    end else begin
                        bit_idx_next_s = bit_idx_r + IDX_ONE;
                    end
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            STOP: begin
                if (tick_s) begin
                    if (rx_s) begin
                        // Back to IDLE at mid stop bit so the next start edge is caught.
                        push_s       = 1'b1;
                        state_next_s = IDLE;
                    end else begin
                        fe_set_s     = 1'b1;
                        state_next_s = BREAK;
                    end
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            BREAK: begin
                // A held-low line must not be decoded as a run of 0x00 frames.
                if (rx_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = BREAK;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // A completed byte is lost only when the FIFO is full and not draining this cycle.
    always_comb begin
        ov_set_s = push_s & fifo_full_s & ~out_ready;
    end

    // FSM state, timer, index and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= IDX_ZERO;
            shift_r   <= {UART_DATA_BITS{1'b0}};
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            bit_idx_r <= bit_idx_next_s;
            shift_r   <= shift_next_s;
        end
    end

    // Registered status outputs; busy tracks the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fe_r   <= 1'b0;
            ov_r   <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            fe_r   <= fe_set_s;
            ov_r   <= ov_set_s;
            busy_r <= (state_next_s != IDLE);
        end
    end

    xc_byte_fifo #(
        .WIDTH(UART_DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push_s),
        .din  (shift_r),
        .pop  (out_ready),
        .dout (fifo_dout_s),
        .empty(fifo_empty_s),
        .full (fifo_full_s)
    );

    assign out_data      = fifo_dout_s;
    assign out_valid     = ~fifo_empty_s;
    assign framing_error = fe_r;
    assign overrun       = ov_r;
    assign busy          = busy_r;

endmodule
